// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, transmitter state encoding
// and the parity helper used by both transmit and receive paths.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Data is zero-extended to 9 bits, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd_mode);
    return (^data) ^ odd_mode;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last clock of each bit.
// A restart pulse realigns the count so every frame starts on a fresh period.
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic bit_tick_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB first, optional
// parity, 1-2 stop bits; back-to-back frames when tx_valid stays high.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_bit,
  output logic                 busy
);

  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $fatal(1, "uart_tx_param: illegal parameter value");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_bit_q, tx_bit_d;
  logic                 busy_q, busy_d;
  logic                 bit_tick_s, last_stop_s, ready_s, accept_s;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk_i      (clk),
    .rst_ni     (rst),
    .restart_i  (accept_s),
    .bit_tick_o (bit_tick_s)
  );

  assign last_stop_s = (state_q == ST_STOP) && (bit_cnt_q == 4'(STOP_BITS - 1)) && bit_tick_s;
  assign ready_s     = (state_q == ST_IDLE) || last_stop_s;
  assign accept_s    = tx_valid && ready_s;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tx_bit_d  = tx_bit_q;
    busy_d    = busy_q;
    if (accept_s) begin
      state_d   = ST_START;
      shift_d   = tx_data;
      bit_cnt_d = 4'd0;
      par_d     = parity_bit(9'(tx_data), PARITY == PAR_ODD);
      tx_bit_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (bit_tick_s) begin
      case (state_q)
        ST_START: begin
          state_d   = ST_DATA;
          tx_bit_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 4'd0;
        end
        ST_DATA: begin
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = 4'd0;
            if (PARITY != PAR_NONE) begin
              state_d  = ST_PARITY;
              tx_bit_d = par_q;
            end else begin
              state_d  = ST_STOP;
              tx_bit_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_bit_d  = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
        ST_PARITY: begin
          state_d   = ST_STOP;
          tx_bit_d  = 1'b1;
          bit_cnt_d = 4'd0;
        end
        ST_STOP: begin
          // Reaching here on the final stop bit means no new word was offered.
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            state_d  = ST_IDLE;
            tx_bit_d = 1'b1;
            busy_d   = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= 4'd0;
      par_q     <= 1'b0;
      tx_bit_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_bit_q  <= tx_bit_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_ready = ready_s;
  assign tx_bit   = tx_bit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations side by side, a per-clock line
// scoreboard filled at acceptance and drained on the falling clock edge.
module tb_uart_tx_param;

  localparam int NI = 4;
  localparam int DIV[NI]   = '{4, 4, 4, 2};
  localparam int DBITS[NI] = '{8, 8, 8, 5};
  localparam int PARM[NI]  = '{0, 1, 2, 0};
  localparam int STOPB[NI] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid_s [NI];
  logic [8:0] tx_data_s  [NI];
  logic       tx_ready_s [NI];
  logic       tx_bit_s   [NI];
  logic       busy_s     [NI];

  logic exp_q [NI][$];
  logic cur_par [NI];
  int   acc_cnt [NI];
  int   n_vec = 0;
  int   n_fail = 0;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       par;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_s[0]), .tx_data(tx_data_s[0][7:0]),
    .tx_ready(tx_ready_s[0]), .tx_bit(tx_bit_s[0]), .busy(busy_s[0]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_s[1]), .tx_data(tx_data_s[1][7:0]),
    .tx_ready(tx_ready_s[1]), .tx_bit(tx_bit_s[1]), .busy(busy_s[1]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_s[2]), .tx_data(tx_data_s[2][7:0]),
    .tx_ready(tx_ready_s[2]), .tx_bit(tx_bit_s[2]), .busy(busy_s[2]));
  uart_tx_param #(.CLK_DIV(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_s[3]), .tx_data(tx_data_s[3][4:0]),
    .tx_ready(tx_ready_s[3]), .tx_bit(tx_bit_s[3]), .busy(busy_s[3]));

  task automatic check(input string name, input int i, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %b, expected %b", name, i, $time, act, exp);
    end
  endtask

  task automatic push_frame(input int i, input logic [8:0] d, input logic p);
    logic b;
    for (int k = 0; k < DIV[i]; k++) exp_q[i].push_back(1'b0);
    for (int n = 0; n < DBITS[i]; n++) begin
      b = d[n];
      for (int k = 0; k < DIV[i]; k++) exp_q[i].push_back(b);
    end
    if (PARM[i] != 0) begin
      for (int k = 0; k < DIV[i]; k++) exp_q[i].push_back(p);
    end
    for (int k = 0; k < STOPB[i] * DIV[i]; k++) exp_q[i].push_back(1'b1);
  endtask

  // Model acceptance: a word is taken when offered and no frame clock remains.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        if (tx_valid_s[i] === 1'b1 && exp_q[i].size() == 0) begin
          push_frame(i, tx_data_s[i], cur_par[i]);
          acc_cnt[i]++;
        end
      end
    end
  end

  // Line, busy and ready compared once per clock against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        int sz;
        logic eb;
        sz = exp_q[i].size();
        eb = (sz > 0) ? exp_q[i][0] : 1'b1;
        check("tx_bit", i, tx_bit_s[i], eb);
        check("busy", i, busy_s[i], sz >= 1);
        check("tx_ready", i, tx_ready_s[i], sz <= 1);
        if (sz > 0) void'(exp_q[i].pop_front());
      end
    end
  end

  task automatic send(input int i, input logic [8:0] d, input logic p, input logic keep);
    int start;
    int w;
    @(negedge clk);
    #1;
    start = acc_cnt[i];
    tx_data_s[i]  = d;
    cur_par[i]    = p;
    tx_valid_s[i] = 1'b1;
    w = 0;
    while (acc_cnt[i] == start && w < 300) begin
      @(negedge clk);
      #1;
      w++;
    end
    n_vec++;
    if (acc_cnt[i] == start) begin
      n_fail++;
      $display("FAIL accept[%0d]: word %h never accepted, got count %0d, expected %0d", i, d, acc_cnt[i], start + 1);
    end
    if (!keep) begin
      tx_valid_s[i] = 1'b0;
      tx_data_s[i]  = ~d;
    end
  endtask

  task automatic wait_idle();
    int w;
    bit pend;
    w = 0;
    pend = 1'b1;
    while (pend && w < 500) begin
      @(negedge clk);
      #1;
      w++;
      pend = 1'b0;
      for (int i = 0; i < NI; i++) if (exp_q[i].size() != 0) pend = 1'b1;
    end
    n_vec++;
    if (pend) begin
      n_fail++;
      $display("FAIL idle_timeout: got pending frames after %0d clocks, expected none", w);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int a0;
    tbl[0] = '{0, 9'h0A5, 1'b0};
    tbl[1] = '{1, 9'h007, 1'b1};
    tbl[2] = '{2, 9'h007, 1'b0};
    tbl[3] = '{1, 9'h0A5, 1'b0};
    tbl[4] = '{3, 9'h01F, 1'b0};
    tbl[5] = '{2, 9'h0A5, 1'b1};
    tbl[6] = '{0, 9'h000, 1'b0};
    tbl[7] = '{3, 9'h00A, 1'b0};

    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      tx_valid_s[i] = 1'b0;
      tx_data_s[i]  = 9'h000;
      cur_par[i]    = 1'b0;
      acc_cnt[i]    = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_tx_bit", i, tx_bit_s[i], 1'b1);
      check("rst_busy", i, busy_s[i], 1'b0);
      check("rst_ready", i, tx_ready_s[i], 1'b1);
    end
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      send(tbl[v].inst, tbl[v].data, tbl[v].par, 1'b0);
      wait_idle();
    end

    // Back to back with tx_valid held: 0x55 then 0xAA with no idle gap.
    send(0, 9'h055, 1'b0, 1'b1);
    send(0, 9'h0AA, 1'b0, 1'b0);
    wait_idle();

    // A word offered mid-frame must be ignored, then taken once ready.
    send(0, 9'h081, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    #1;
    a0 = acc_cnt[0];
    tx_data_s[0]  = 9'h03C;
    tx_valid_s[0] = 1'b1;
    @(negedge clk);
    #1;
    tx_valid_s[0] = 1'b0;
    check("stall_no_accept", 0, acc_cnt[0] == a0, 1'b1);
    wait_idle();
    send(0, 9'h03C, 1'b0, 1'b0);
    wait_idle();

    // Reset mid-frame: line returns high at once and stays idle afterwards.
    send(0, 9'h000, 1'b0, 1'b0);
    send(3, 9'h000, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("midrst_tx_bit", i, tx_bit_s[i], 1'b1);
      check("midrst_busy", i, busy_s[i], 1'b0);
      check("midrst_ready", i, tx_ready_s[i], 1'b1);
      exp_q[i].delete();
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (40) @(negedge clk);

    send(3, 9'h015, 1'b0, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
